instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage of the MIPS datapath. Sits directly upstream of the instruction memory. Owns the program counter and drives the memory's word address. Collects the instruction returned one cycle later and hands {instruction, PC, PC+4} to decode over a valid/ready handshake. Supports back-pressure from decode and PC redirect (branch/jump) from later stages.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (bits [1:0] must be 0)
DEPTH, 2, entries in the output queue; power of two, >=2

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_addr  output  32  word address to instruction memory = {2'b00, pc[31:2]}
imem_instr  input  32  registered memory read data; corresponds to imem_addr sampled at the previous edge
redirect_valid  input  1  pulse: discard all fetched/in-flight work, restart at redirect_pc
redirect_pc  input  32  byte target address; bits [1:0] ignored (treated as 0)
out_valid  output  1  queue head holds a valid fetched instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  head instruction
out_pc  output  32  head byte PC
out_pc_plus4  output  32  out_pc + 4, modulo 2^32

Behaviour:
- Reset (async): pc=RESET_PC; inflight=0; queue empty; out_valid=0; out_instr/out_pc=0; out_pc_plus4=4. imem_addr=RESET_PC>>2 while in reset.
- The memory reads every edge with no enable. The block must qualify responses itself.
- State: pc reg; inflight bit + inflight_pc reg; circular queue of DEPTH {instr, pc} with rd/wr pointers and count (0..DEPTH).
- pop = out_valid & out_ready. Outputs come from the queue head register, with no bypass from imem_instr.
- issue = !redirect_valid & (count + inflight - pop < DEPTH). On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (wrap 2^32). Otherwise inflight<=0 and pc holds.
- Response: if inflight=1 and no redirect this cycle, push {imem_instr, inflight_pc} into the queue at the edge. The issue rule guarantees the queue never overflows; a push into a full queue is an assertion failure.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (highest priority): at the edge, pc<={redirect_pc[31:2],2'b00}; inflight<=0; queue flushed (count=0, pointers reset). No push occurs that cycle. A pop in the same cycle still counts as consumed by decode.
- Redirect while queue empty or full, or with out_ready=0: same flush. Back-to-back redirects: the last one wins.
- Latency: the first issue occurs at the 1st edge after reset release or redirect. out_valid rises after the 2nd edge. Sustained throughput is 1 instr/cycle with out_ready=1 and DEPTH>=2.
- Back-pressure: out_ready=0 holds the head stable, with out_valid held high. Fetch stops issuing once count+inflight reaches DEPTH. No instruction is lost or duplicated.
- Reset mid-operation: immediately returns to the reset state; pending entries are dropped.
- Timing: out_ready feeds issue combinationally. imem_addr is a pure function of the pc register.

Test Plan:
- Memory model mem[k]=32'h1000_0000+k, out_ready=1, release reset -> out_valid rises after edge 2; then out_pc 0,4,8,… every cycle with out_instr 0x10000000,1,2,…; out_pc_plus4=out_pc+4.
- Hold out_ready=0 for 5 cycles mid-stream at head pc=0x10 -> head stays 0x10/0x10000004; count saturates at DEPTH; pc advances at most DEPTH beyond the head. After release, the stream resumes 0x10,0x14,… with no gap and no duplicates.
- redirect_valid=1, redirect_pc=0x203 for one cycle while the queue is full -> out_valid=0 next cycle; out_valid returns 2 edges later with out_pc=0x200, out_instr=mem[0x80]. No older PC appears.
- Redirect and pop in the same cycle, followed by a second redirect to 0x40 on the next cycle -> only the stream from 0x40 appears.
- PC wrap: RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 of the last entry is 0x4.
- Assert reset for 1 cycle mid-stream with out_ready toggling -> out_valid drops immediately, imem_addr=RESET_PC>>2, and the stream restarts from RESET_PC with 2-edge latency.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-memory port, the redirect request from later stages
// and the valid/ready handoff to decode.
//   master : the fetch block (drives imem_addr and the out_* payload)
//   slave  : the environment (memory, redirect source, decode)
// Signals:
//   imem_addr      word address to instruction memory
//   imem_instr     registered read data for the address of the previous edge
//   redirect_valid restart request, redirect_pc is its byte target
//   out_valid/out_ready handshake, out_instr/out_pc/out_pc_plus4 payload
interface instruction_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage.
// Owns the program counter, drives the instruction memory word address every
// cycle, captures the data that comes back one edge later and queues
// {instruction, pc} for decode behind a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    instruction_fetch_if.master (memory port, redirect, decode handoff)
// Parameters:
//   RESET_PC  byte address of the first fetch after reset (word aligned)
//   DEPTH     output queue entries, power of two, at least 2
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  // Memory address is a pure function of the pc register.
  assign bus.imem_addr = {2'b00, pc[31:2]};

  // Decode sees the queue head register only, never the raw memory data.
  assign bus.out_valid    = (count != '0);
  assign bus.out_instr    = q_instr[rd_ptr];
  assign bus.out_pc       = q_pc[rd_ptr];
  assign bus.out_pc_plus4 = q_pc[rd_ptr] + 32'd4;

  // Issue only when the queue can hold every response already owed to it,
  // crediting an entry that decode is taking this same cycle. Because the
  // memory has no enable, the inflight bit is what marks a returning word as
  // one we actually asked for.
  assign pop       = bus.out_valid & bus.out_ready;
  assign push      = inflight & ~bus.redirect_valid;
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue     = ~bus.redirect_valid & (occupancy < DEPTH_OCC);

  // PC, in-flight tracking and the circular output queue. A redirect wins
  // over everything: it retargets the pc, forgets the in-flight read and
  // empties the queue, so nothing fetched before it can reach decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      pc       <= {bus.redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end else begin
        inflight <= 1'b0;
      end

      if (push) begin
        q_instr[wr_ptr] <= bus.imem_instr;
        q_pc[wr_ptr]    <= inflight_pc;
        wr_ptr          <= wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // The issue rule should make a push into a full queue impossible.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && count == DEPTH_CNT));
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// A behavioural memory returns mem[k] = 0x1000_0000 + k one edge after the
// address. Every time a stream starts (reset release or redirect) the bench
// pushes the expected {pc, instr, pc+4} sequence into a scoreboard queue and
// pops/compares one entry whenever decode accepts an instruction.
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic reset_wrap = 1'b1;
  int   checks     = 0;
  int   failures   = 0;

  fetch_entry_t sb[$];
  fetch_entry_t sbw[$];

  instruction_fetch_if bus();
  instruction_fetch_if bus_wrap();

  instruction_fetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  instruction_fetch #(
    .RESET_PC(32'hFFFF_FFF8),
    .DEPTH   (2)
  ) dut_wrap (
    .clk  (clk),
    .reset(reset_wrap),
    .bus  (bus_wrap.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] word_addr);
    return 32'h1000_0000 + word_addr;
  endfunction

  // Registered instruction memories, reading every edge with no enable.
  always @(posedge clk) begin
    bus.imem_instr      <= mem_word(bus.imem_addr);
    bus_wrap.imem_instr <= mem_word(bus_wrap.imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Expected stream starting at start_pc, n instructions long.
  task automatic applyStimulus(input logic [31:0] start_pc, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc       = start_pc + 32'(4 * i);
      e.instr    = mem_word({2'b00, e.pc[31:2]});
      e.pc_plus4 = e.pc + 32'd4;
      sb.push_back(e);
    end
  endtask

  // One clock: drive inputs at the falling edge, check any accepted
  // instruction, reload the scoreboard on a redirect, then advance.
  task automatic run_cycle(input logic ready, input logic redir, input logic [31:0] rpc);
    fetch_entry_t e;
    bus.out_ready      = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    if (bus.out_valid && ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pop", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("out_pc", bus.out_pc, e.pc);
        checkOutput("out_instr", bus.out_instr, e.instr);
        checkOutput("out_pc_plus4", bus.out_pc_plus4, e.pc_plus4);
      end
    end
    if (redir) begin
      sb.delete();
      applyStimulus({rpc[31:2], 2'b00}, 64);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    fetch_entry_t w;

    bus.out_ready           = 1'b0;
    bus.redirect_valid      = 1'b0;
    bus.redirect_pc         = '0;
    bus_wrap.out_ready      = 1'b1;
    bus_wrap.redirect_valid = 1'b0;
    bus_wrap.redirect_pc    = '0;

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_instr", bus.out_instr, 32'd0);
    checkOutput("rst_pc", bus.out_pc, 32'd0);
    checkOutput("rst_pc_plus4", bus.out_pc_plus4, 32'd4);
    checkOutput("rst_addr", bus.imem_addr, 32'd0);

    // Stream from reset, two-edge latency, then run to head pc 0x10.
    reset = 1'b0;
    applyStimulus(32'h0, 200);
    for (int i = 0; i < 6; i++) begin
      if (i < 2) checkOutput("lat_valid_low", 32'(bus.out_valid), 32'd0);
      if (i == 2) checkOutput("lat_valid_high", 32'(bus.out_valid), 32'd1);
      run_cycle(1'b1, 1'b0, 32'h0);
    end
    checkOutput("start_pops", 32'(sb.size()), 32'd196);

    // Back-pressure: head frozen, fetch stops DEPTH words past the head.
    $display("[TB] back-pressure");
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b0, 32'h0);
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_pc", bus.out_pc, 32'h10);
      checkOutput("hold_instr", bus.out_instr, 32'h1000_0004);
    end
    checkOutput("hold_fetch_addr", bus.imem_addr, 32'h6);
    for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 32'h0);
    checkOutput("resume_pops", 32'(sb.size()), 32'd186);

    // Redirect while the queue is full and decode is stalled.
    $display("[TB] redirect on full queue");
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b1, 32'h203);
    checkOutput("redir_valid_drop", 32'(bus.out_valid), 32'd0);
    run_cycle(1'b1, 1'b0, 32'h0);
    checkOutput("redir_valid_low", 32'(bus.out_valid), 32'd0);
    run_cycle(1'b1, 1'b0, 32'h0);
    checkOutput("redir_valid_high", 32'(bus.out_valid), 32'd1);
    checkOutput("redir_pc", bus.out_pc, 32'h200);
    checkOutput("redir_instr", bus.out_instr, 32'h1000_0080);
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 32'h0);
    checkOutput("redir_pops", 32'(sb.size()), 32'd56);

    // Redirect with a same-cycle pop, then a second redirect next cycle.
    $display("[TB] back-to-back redirect");
    run_cycle(1'b1, 1'b1, 32'h300);
    run_cycle(1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 32'h0);
    checkOutput("b2b_pops", 32'(sb.size()), 32'd56);

    // Reset pulse mid-stream with a toggling out_ready.
    $display("[TB] reset mid-stream");
    for (int i = 0; i < 6; i++) run_cycle(1'(i % 2 == 0), 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mrst_addr", bus.imem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    applyStimulus(32'h0, 64);
    for (int i = 0; i < 10; i++) begin
      if (i < 2) checkOutput("mrst_lat_low", 32'(bus.out_valid), 32'd0);
      if (i == 2) checkOutput("mrst_lat_high", 32'(bus.out_valid), 32'd1);
      run_cycle(1'b1, 1'b0, 32'h0);
    end
    checkOutput("mrst_pops", 32'(sb.size()), 32'd56);

    // PC wrap through 2^32 on the second instance.
    $display("[TB] pc wrap");
    reset_wrap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w.pc       = 32'hFFFF_FFF8 + 32'(4 * i);
      w.instr    = mem_word({2'b00, w.pc[31:2]});
      w.pc_plus4 = w.pc + 32'd4;
      sbw.push_back(w);
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus_wrap.out_valid) begin
        if (sbw.size() == 0) begin
          checkOutput("wrap_unexpected", 32'(bus_wrap.out_valid), 32'd0);
        end else begin
          w = sbw.pop_front();
          checkOutput("wrap_pc", bus_wrap.out_pc, w.pc);
          checkOutput("wrap_instr", bus_wrap.out_instr, w.instr);
          checkOutput("wrap_pc_plus4", bus_wrap.out_pc_plus4, w.pc_plus4);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("wrap_drain", 32'(sbw.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
